rtc_time_counter: RTL

- BCD hours/minutes/seconds time-of-day counter driven by an internal 1 Hz prescaler.
- Upstream source of the current-time bytes that the alarm equality comparator compares against the stored alarm time.
- Supports synchronous time load and per-field increment pulses for the time-set buttons.

---
 rtl/rtc_time_counter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rtc_time_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rtc_time_counter : BCD hh:mm:ss time-of-day counter with 1 Hz prescaler,   |
// |                    validated time load and per-field set increments.       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module rtc_time_counter #(
  parameter int CLK_DIV = 50000000,
  parameter int CNT_W   = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] ld_hh,
  input  logic [7:0] ld_mm,
  input  logic [7:0] ld_ss,
  input  logic       inc_hh,
  input  logic       inc_mm,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err
);

  localparam logic [CNT_W-1:0] c_presc_max = CNT_W'(CLK_DIV - 1);
  localparam logic [7:0]       c_hh_max    = 8'h23;
  localparam logic [7:0]       c_ms_max    = 8'h59;

  logic [CNT_W-1:0] r_presc;
  logic [7:0]       r_hh, r_mm, r_ss;
  logic             r_sec_tick, r_day_wrap, r_load_err;

  logic [CNT_W-1:0] w_presc_nxt;
  logic [7:0]       w_hh_nxt, w_mm_nxt, w_ss_nxt;
  logic             w_tick, w_inc, w_ld_ok, w_load_ok, w_advance, w_day_wrap;

  // BCD +1 with wrap to 00 once the field maximum is reached
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [3:0] max_tens);
    return (v[7:4] <= max_tens) && (v[3:0] <= 4'd9);
  endfunction

  assign w_tick    = run && (r_presc == c_presc_max);
  assign w_inc     = inc_hh | inc_mm;
  assign w_ld_ok   = bcd_ok(ld_hh, 4'd2) && (ld_hh <= c_hh_max) &&
                     bcd_ok(ld_mm, 4'd5) && bcd_ok(ld_ss, 4'd5);
  assign w_load_ok = load && w_ld_ok;
  // A tick only reaches the time registers when nothing of higher priority acts
  assign w_advance = w_tick && !w_load_ok && !w_inc;
  assign w_day_wrap = w_advance && (r_hh == c_hh_max) &&
                      (r_mm == c_ms_max) && (r_ss == c_ms_max);

  always_comb begin
    w_hh_nxt = r_hh;
    w_mm_nxt = r_mm;
    w_ss_nxt = r_ss;
    if (w_load_ok) begin
      w_hh_nxt = ld_hh;
      w_mm_nxt = ld_mm;
      w_ss_nxt = ld_ss;
    end else if (w_inc) begin
      if (inc_hh)
        w_hh_nxt = bcd_inc(r_hh, c_hh_max);
      if (inc_mm) begin
        w_mm_nxt = bcd_inc(r_mm, c_ms_max);
        w_ss_nxt = 8'h00;
      end
    end else if (w_tick) begin
      w_ss_nxt = bcd_inc(r_ss, c_ms_max);
      if (r_ss == c_ms_max) begin
        w_mm_nxt = bcd_inc(r_mm, c_ms_max);
        if (r_mm == c_ms_max)
          w_hh_nxt = bcd_inc(r_hh, c_hh_max);
      end
    end
  end

  // The prescaler wraps on a tick cycle even when an increment drops the tick
  always_comb begin
    w_presc_nxt = r_presc + CNT_W'(1);
    if (w_load_ok || !run || w_tick)
      w_presc_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_hh       <= 8'h00;
      r_mm       <= 8'h00;
      r_ss       <= 8'h00;
      r_sec_tick <= 1'b0;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_presc    <= w_presc_nxt;
      r_hh       <= w_hh_nxt;
      r_mm       <= w_mm_nxt;
      r_ss       <= w_ss_nxt;
      r_sec_tick <= w_advance;
      r_day_wrap <= w_day_wrap;
      r_load_err <= load && !w_ld_ok;
    end
  end

  assign hours    = r_hh;
  assign minutes  = r_mm;
  assign seconds  = r_ss;
  assign sec_tick = r_sec_tick;
  assign day_wrap = r_day_wrap;
  assign load_err = r_load_err;

endmodule
`default_nettype wire
